// File: rtl/dff_bank_arbiter_pkg.sv
// =============================================================================
// Module      : dff_arb_pkg
// Description : Shared op and FSM state encodings for the flop-bank arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package dff_arb_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } dff_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_APPLY = 2'b01,
        S_ACK   = 2'b10
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/dff_bank_arbiter_if.sv
// =============================================================================
// Module      : dff_bank_arbiter_if
// Description : Requester-side bus of the flop-bank arbiter (req/op/data in,
//               grant/done/busy/q out).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface dff_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  done;
    logic                  busy;
    logic [WIDTH-1:0]      q;

    modport master (
        output req, req_op, req_data,
        input  gnt, done, busy, q
    );

    modport slave (
        input  req, req_op, req_data,
        output gnt, done, busy, q
    );
endinterface

`default_nettype wire

// File: rtl/dff_bank_arbiter_bank.sv
// =============================================================================
// Module      : dff_bank
// Description : WIDTH-bit flop bank with clear/set/load, clear highest priority.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module dff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             set,
    input  wire logic             clr,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= RESET_VAL;
        end else if (clr) begin
            r_q <= '0;
        end else if (set) begin
            r_q <= '1;
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/dff_bank_arbiter.sv
// =============================================================================
// Module      : dff_bank_arbiter
// Description : Round-robin arbiter granting NREQ requesters access to one
//               shared flop bank; IDLE -> APPLY -> ACK per operation.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter int               NREQ      = 4,
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    dff_bank_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(NREQ);

    arb_state_e       r_state;
    logic [NREQ-1:0]  r_gnt;
    logic             r_done;
    logic             r_busy;
    logic [IDX_W-1:0] r_rr_ptr;
    dff_op_e          r_op;
    logic [WIDTH-1:0] r_data;

    logic             w_found;
    logic [NREQ-1:0]  w_win_onehot;
    dff_op_e          w_win_op;
    logic [WIDTH-1:0] w_win_data;
    logic [IDX_W-1:0] w_next_ptr;
    logic             w_apply;
    logic             w_set;
    logic             w_clr;
    logic             w_load;

    // First requester at or after the rotating pointer, wrapping past NREQ-1.
    always_comb begin
        int idx;
        w_found      = 1'b0;
        w_win_onehot = '0;
        w_win_op     = OP_NOP;
        w_win_data   = '0;
        w_next_ptr   = '0;
        idx          = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(r_rr_ptr) + i) % NREQ;
            if (!w_found && bus.req[idx]) begin
                w_found           = 1'b1;
                w_win_onehot[idx] = 1'b1;
                w_win_op          = dff_op_e'(bus.req_op[2*idx +: 2]);
                w_win_data        = bus.req_data[WIDTH*idx +: WIDTH];
                w_next_ptr        = IDX_W'((idx + 1) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_rr_ptr <= '0;
            r_op     <= OP_NOP;
            r_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_found) begin
                        r_op     <= w_win_op;
                        r_data   <= w_win_data;
                        r_gnt    <= w_win_onehot;
                        r_rr_ptr <= w_next_ptr;
                        r_busy   <= 1'b1;
                        r_state  <= S_APPLY;
                    end else begin
                        r_gnt  <= '0;
                        r_busy <= 1'b0;
                    end
                end
                S_APPLY: begin
                    r_done  <= 1'b1;
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    r_done  <= 1'b0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Bank commits the latched op on the edge that leaves APPLY.
    assign w_apply = (r_state == S_APPLY);
    assign w_clr   = w_apply && (r_op == OP_CLEAR);
    assign w_set   = w_apply && (r_op == OP_SET);
    assign w_load  = w_apply && (r_op == OP_LOAD);

    dff_bank #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .set   (w_set),
        .clr   (w_clr),
        .load  (w_load),
        .d     (r_data),
        .q     (bus.q)
    );

    assign bus.gnt  = r_gnt;
    assign bus.done = r_done;
    assign bus.busy = r_busy;

endmodule

`default_nettype wire
